// File: rtl/pong_pkg.sv
// Shared geometry defaults, state encoding and direction encoding for the pong ball engine.
package pong_pkg;

    localparam int SCREEN_W_DEF    = 640;
    localparam int SCREEN_H_DEF    = 480;
    localparam int BALL_SIZE_DEF   = 8;
    localparam int PADDLE_H_DEF    = 64;
    localparam int PADDLE_W_DEF    = 8;
    localparam int PADDLE_L_X_DEF  = 16;
    localparam int PADDLE_R_X_DEF  = 616;
    localparam int STEP_DEF        = 2;
    localparam int SERVE_DELAY_DEF = 60;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_SCORED = 2'd2
    } state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_x_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_y_t;

    function automatic dir_x_t flip_x(input dir_x_t d);
        return (d == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
    endfunction

endpackage

// File: rtl/pong_tick_delay.sv
// Tick-qualified down-counter: loaded with a count, expires on the tick that takes it from 1 to 0.
module pong_tick_delay #(
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_count;

    // Load has priority; otherwise count down one per tick and rest at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_count <= i_count;
        end else if (i_tick && (r_count != {CNT_W{1'b0}})) begin
            r_count <= r_count - CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expire = i_tick && !i_load && (r_count == CNT_W'(1));

endmodule

// File: rtl/pong_ball_engine.sv
// Ball motion, wall/paddle collision and serve/play/scored sequencing for a pong game.
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int BALL_SIZE   = BALL_SIZE_DEF,
    parameter int PADDLE_H    = PADDLE_H_DEF,
    parameter int PADDLE_W    = PADDLE_W_DEF,
    parameter int PADDLE_L_X  = PADDLE_L_X_DEF,
    parameter int PADDLE_R_X  = PADDLE_R_X_DEF,
    parameter int STEP        = STEP_DEF,
    parameter int SERVE_DELAY = SERVE_DELAY_DEF
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       tick,
    input  logic       serve,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       in_play,
    output logic       serve_ready,
    output logic       point_l,
    output logic       point_r
);

    localparam logic [10:0] L_W      = 11'(SCREEN_W);
    localparam logic [10:0] L_H      = 11'(SCREEN_H);
    localparam logic [10:0] L_BALL   = 11'(BALL_SIZE);
    localparam logic [10:0] L_PH     = 11'(PADDLE_H);
    localparam logic [10:0] L_L_FACE = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic [10:0] L_RX     = 11'(PADDLE_R_X);
    localparam logic [10:0] L_STEP   = 11'(STEP);
    localparam logic [9:0]  CENTRE_X = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]  CENTRE_Y = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam int          DLY_W    = $clog2(SERVE_DELAY + 1);

    state_t     r_state;
    dir_x_t     r_dx;
    dir_x_t     r_serve_dir;
    dir_y_t     r_dy;
    logic [9:0] r_ball_x;
    logic [9:0] r_ball_y;
    logic       r_in_play;
    logic       r_serve_ready;
    logic       r_point_l;
    logic       r_point_r;

    logic [10:0] w_bx, w_by, w_pl, w_pr;
    logic        w_hit_l, w_hit_r, w_miss_l, w_miss_r;
    logic [9:0]  w_nx, w_ny;
    dir_x_t      w_ndx;
    dir_y_t      w_ndy;
    logic        w_load, w_dly_tick, w_expire;

    // All collision arithmetic is done one bit wider so sums never wrap.
    assign w_bx = {1'b0, r_ball_x};
    assign w_by = {1'b0, r_ball_y};
    assign w_pl = {1'b0, paddle_l_y};
    assign w_pr = {1'b0, paddle_r_y};

    assign w_hit_l = (r_dx == DIR_LEFT) && (w_bx >= L_L_FACE) && ((w_bx - L_STEP) <= L_L_FACE)
                     && ((w_by + L_BALL) > w_pl) && (w_by < (w_pl + L_PH));
    assign w_hit_r = (r_dx == DIR_RIGHT) && ((w_bx + L_BALL) <= L_RX) && ((w_bx + L_BALL + L_STEP) >= L_RX)
                     && ((w_by + L_BALL) > w_pr) && (w_by < (w_pr + L_PH));

    // Vertical move with clamp-and-bounce at the top and bottom walls.
    always_comb begin
        w_ny  = r_ball_y;
        w_ndy = r_dy;
        if (r_dy == DIR_UP) begin
            if (w_by < L_STEP) begin
                w_ny  = 10'd0;
                w_ndy = DIR_DOWN;
            end else begin
                w_ny = 10'(w_by - L_STEP);
            end
        end else begin
            if ((w_by + L_BALL + L_STEP) > L_H) begin
                w_ny  = 10'(L_H - L_BALL);
                w_ndy = DIR_UP;
            end else begin
                w_ny = 10'(w_by + L_STEP);
            end
        end
    end

    // Horizontal move: paddle hits snap to the paddle face, misses clamp at the edge.
    always_comb begin
        w_nx     = r_ball_x;
        w_ndx    = r_dx;
        w_miss_l = 1'b0;
        w_miss_r = 1'b0;
        if (w_hit_l) begin
            w_nx  = 10'(L_L_FACE);
            w_ndx = DIR_RIGHT;
        end else if (w_hit_r) begin
            w_nx  = 10'(L_RX - L_BALL);
            w_ndx = DIR_LEFT;
        end else if (r_dx == DIR_LEFT) begin
            if (w_bx < L_STEP) begin
                w_nx     = 10'd0;
                w_miss_l = 1'b1;
            end else begin
                w_nx = 10'(w_bx - L_STEP);
            end
        end else begin
            if ((w_bx + L_BALL + L_STEP) > L_W) begin
                w_nx     = 10'(L_W - L_BALL);
                w_miss_r = 1'b1;
            end else begin
                w_nx = 10'(w_bx + L_STEP);
            end
        end
    end

    assign w_load     = (r_state == ST_PLAY) && tick && (w_miss_l || w_miss_r);
    assign w_dly_tick = tick && (r_state == ST_SCORED);

    pong_tick_delay #(
        .CNT_W (DLY_W)
    ) u_serve_delay (
        .i_clk    (CLOCK_50),
        .i_rst_n  (reset),
        .i_load   (w_load),
        .i_tick   (w_dly_tick),
        .i_count  (DLY_W'(SERVE_DELAY)),
        .o_expire (w_expire)
    );

    // Serve/play/scored sequencer with registered position, status and point pulses.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_dx          <= DIR_RIGHT;
            r_dy          <= DIR_DOWN;
            r_serve_dir   <= DIR_RIGHT;
            r_ball_x      <= CENTRE_X;
            r_ball_y      <= CENTRE_Y;
            r_in_play     <= 1'b0;
            r_serve_ready <= 1'b1;
            r_point_l     <= 1'b0;
            r_point_r     <= 1'b0;
        end else begin
            r_point_l <= 1'b0;
            r_point_r <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ball_x <= CENTRE_X;
                    r_ball_y <= CENTRE_Y;
                    if (serve) begin
                        r_state       <= ST_PLAY;
                        r_dx          <= r_serve_dir;
                        r_serve_dir   <= flip_x(r_serve_dir);
                        r_in_play     <= 1'b1;
                        r_serve_ready <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        r_ball_x <= w_nx;
                        r_ball_y <= w_ny;
                        r_dx     <= w_ndx;
                        r_dy     <= w_ndy;
                        if (w_miss_l || w_miss_r) begin
                            r_state   <= ST_SCORED;
                            r_in_play <= 1'b0;
                            r_point_r <= w_miss_l;
                            r_point_l <= w_miss_r;
                        end
                    end
                end
                ST_SCORED: begin
                    if (w_expire) begin
                        r_state       <= ST_IDLE;
                        r_ball_x      <= CENTRE_X;
                        r_ball_y      <= CENTRE_Y;
                        r_serve_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_in_play     <= 1'b0;
                    r_serve_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ball_x      = r_ball_x;
    assign ball_y      = r_ball_y;
    assign in_play     = r_in_play;
    assign serve_ready = r_serve_ready;
    assign point_l     = r_point_l;
    assign point_r     = r_point_r;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Self-checking bench for pong_ball_engine against a velocity-based behavioural model of the game rules.
module tb_pong_ball_engine;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       serve = 1'b0;
    logic [9:0] paddle_l_y = 10'd0;
    logic [9:0] paddle_r_y = 10'd0;
    logic [9:0] ball_x, ball_y;
    logic       in_play, serve_ready, point_l, point_r;

    pong_ball_engine dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .tick        (tick),
        .serve       (serve),
        .paddle_l_y  (paddle_l_y),
        .paddle_r_y  (paddle_r_y),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .in_play     (in_play),
        .serve_ready (serve_ready),
        .point_l     (point_l),
        .point_r     (point_r)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    localparam int S_IDLE = 0, S_PLAY = 1, S_SCORED = 2;
    localparam logic [23:0] RST_VEC = {10'd316, 10'd236, 1'b0, 1'b1, 1'b0, 1'b0};

    int checks = 0;
    int failures = 0;

    // model: position plus signed per-tick velocity
    int m_x, m_y, m_vx, m_vy, m_serve_vx, m_state, m_cnt;
    bit m_pl, m_pr;
    int m_top, m_bot, m_lhits, m_rhits, m_scores;

    wire [23:0] obs = {ball_x, ball_y, in_play, serve_ready, point_l, point_r};

    function automatic logic [23:0] exp_vec();
        return {10'(m_x), 10'(m_y), 1'(m_state == S_PLAY), 1'(m_state == S_IDLE), m_pl, m_pr};
    endfunction

    function automatic logic [9:0] track(input int y);
        return (y >= 20) ? 10'(y - 20) : 10'd0;
    endfunction

    function automatic logic [9:0] away(input int y);
        return (y < 240) ? 10'd400 : 10'd0;
    endfunction

    task automatic model_reset();
        m_x = 316; m_y = 236; m_vx = 2; m_vy = 2; m_serve_vx = 2;
        m_state = S_IDLE; m_cnt = 0; m_pl = 1'b0; m_pr = 1'b0;
    endtask

    task automatic model_step(input bit t, input bit s, input int pl, input int pr);
        int nx, ny;
        m_pl = 1'b0;
        m_pr = 1'b0;
        if (m_state == S_IDLE) begin
            if (s) begin
                m_state = S_PLAY;
                m_vx = m_serve_vx;
                m_serve_vx = -m_serve_vx;
            end
        end else if (m_state == S_PLAY) begin
            if (t) begin
                if (m_vy < 0) begin
                    if (m_y < 2) begin ny = 0; m_vy = 2; m_top++; end
                    else ny = m_y - 2;
                end else begin
                    if (m_y + 8 + 2 > 480) begin ny = 472; m_vy = -2; m_bot++; end
                    else ny = m_y + 2;
                end
                if (m_vx < 0 && m_x >= 24 && m_x - 2 <= 24 && m_y + 8 > pl && m_y < pl + 64) begin
                    nx = 24; m_vx = 2; m_lhits++;
                end else if (m_vx > 0 && m_x + 8 <= 616 && m_x + 10 >= 616 && m_y + 8 > pr && m_y < pr + 64) begin
                    nx = 608; m_vx = -2; m_rhits++;
                end else if (m_vx < 0 && m_x < 2) begin
                    nx = 0; m_pr = 1'b1; m_state = S_SCORED; m_cnt = 0; m_scores++;
                end else if (m_vx > 0 && m_x + 10 > 640) begin
                    nx = 632; m_pl = 1'b1; m_state = S_SCORED; m_cnt = 0; m_scores++;
                end else begin
                    nx = m_x + m_vx;
                end
                m_x = nx;
                m_y = ny;
            end
        end else begin
            if (t) begin
                m_cnt++;
                if (m_cnt == 60) begin
                    m_state = S_IDLE; m_x = 316; m_y = 236;
                end
            end
        end
    endtask

    // Called at a falling edge: drive inputs, advance model at the rising edge, return at the next falling edge.
    task automatic step_cycle(input logic t, input logic s);
        tick = t;
        serve = s;
        @(posedge CLOCK_50);
        model_step(t, s, int'(paddle_l_y), int'(paddle_r_y));
        @(negedge CLOCK_50);
        tick = 1'b0;
        serve = 1'b0;
    endtask

    task automatic test_reset();
        #5 reset = 1'b0;
        model_reset();
        repeat (2) @(negedge CLOCK_50);
        checks++;
        if (obs !== RST_VEC) begin
            failures++;
            $display("FAIL reset_hold got %h want %h", obs, RST_VEC);
        end
        reset = 1'b1;
        step_cycle(1'b0, 1'b0);
        checks++;
        if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL reset_release got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 10; i++) begin
            paddle_l_y = 10'($urandom_range(0, 1023));
            paddle_r_y = 10'($urandom_range(0, 1023));
            step_cycle(1'b1, 1'b0);
            checks++;
            if (obs !== RST_VEC || obs !== exp_vec()) begin
                failures++;
                $display("FAIL idle_hold i=%0d got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_serve_tick_same_cycle();
        step_cycle(1'b1, 1'b1);
        checks++;
        if (obs !== exp_vec() || {ball_x, ball_y, in_play} !== {10'd316, 10'd236, 1'b1}) begin
            failures++;
            $display("FAIL serve_same_tick got x=%0d y=%0d ip=%b sr=%b", ball_x, ball_y, in_play, serve_ready);
        end
        step_cycle(1'b0, 1'b0);
        step_cycle(1'b1, 1'b0);
        checks++;
        if (obs !== exp_vec() || {ball_x, ball_y} !== {10'd318, 10'd238}) begin
            failures++;
            $display("FAIL first_move got x=%0d y=%0d want x=318 y=238", ball_x, ball_y);
        end
    endtask

    task automatic test_bounces();
        int i;
        m_top = 0; m_bot = 0; m_lhits = 0; m_rhits = 0;
        for (i = 0; i < 4000 && (m_top == 0 || m_bot == 0 || m_lhits == 0 || m_rhits == 0); i++) begin
            paddle_l_y = track(m_y);
            paddle_r_y = track(m_y);
            step_cycle(1'($urandom_range(0, 1)), 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL bounce i=%0d got x=%0d y=%0d ip=%b pl=%b pr=%b want x=%0d y=%0d st=%0d",
                         i, ball_x, ball_y, in_play, point_l, point_r, m_x, m_y, m_state);
            end
        end
        checks++;
        if (m_top == 0 || m_bot == 0 || m_lhits == 0 || m_rhits == 0) begin
            failures++;
            $display("FAIL bounce_timeout top=%0d bot=%0d lhit=%0d rhit=%0d want all nonzero",
                     m_top, m_bot, m_lhits, m_rhits);
        end
    endtask

    task automatic test_miss();
        int i;
        int pr_hi = 0;
        bit scored = 1'b0;
        for (i = 0; i < 4000 && !(scored && m_state == S_IDLE); i++) begin
            paddle_l_y = away(m_y);
            paddle_r_y = track(m_y);
            step_cycle(1'b1, 1'(m_state == S_SCORED));
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL miss i=%0d got x=%0d y=%0d ip=%b sr=%b pl=%b pr=%b want x=%0d y=%0d st=%0d pr=%b",
                         i, ball_x, ball_y, in_play, serve_ready, point_l, point_r, m_x, m_y, m_state, m_pr);
            end
            if (point_r === 1'b1) pr_hi++;
            if (m_state == S_SCORED) scored = 1'b1;
        end
        checks++;
        if (!(scored && m_state == S_IDLE)) begin
            failures++;
            $display("FAIL miss_timeout scored=%b state=%0d want scored and idle", scored, m_state);
        end
        checks++;
        if (pr_hi != 1) begin
            failures++;
            $display("FAIL point_r_width got %0d cycles want 1", pr_hi);
        end
        checks++;
        if ({ball_x, ball_y, serve_ready} !== {10'd316, 10'd236, 1'b1}) begin
            failures++;
            $display("FAIL recentre got x=%0d y=%0d sr=%b want 316 236 1", ball_x, ball_y, serve_ready);
        end
        step_cycle(1'b0, 1'b1);
        step_cycle(1'b1, 1'b0);
        checks++;
        if (ball_x !== 10'd314 || obs !== exp_vec()) begin
            failures++;
            $display("FAIL second_serve_left got x=%0d y=%0d want x=314 y=%0d", ball_x, ball_y, m_y);
        end
    endtask

    task automatic test_random();
        int scores_at_start = m_scores;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                paddle_l_y = 10'($urandom_range(0, 1023));
                paddle_r_y = 10'($urandom_range(0, 1023));
            end else begin
                paddle_l_y = track(m_y);
                paddle_r_y = track(m_y);
            end
            step_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL random i=%0d got x=%0d y=%0d ip=%b sr=%b pl=%b pr=%b want x=%0d y=%0d st=%0d pl=%b pr=%b",
                         i, ball_x, ball_y, in_play, serve_ready, point_l, point_r, m_x, m_y, m_state, m_pl, m_pr);
            end
        end
        checks++;
        if (m_scores == scores_at_start) begin
            failures++;
            $display("FAIL random_no_score got %0d points want at least 1", m_scores - scores_at_start);
        end
    endtask

    task automatic test_reset_mid_play();
        for (int i = 0; i < 300 && m_state != S_PLAY; i++) begin
            step_cycle(1'b1, 1'b1);
        end
        repeat (5) begin
            paddle_l_y = track(m_y);
            paddle_r_y = track(m_y);
            step_cycle(1'b1, 1'b0);
        end
        checks++;
        if (in_play !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_play got ip=%b want 1", in_play);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (obs !== RST_VEC) begin
            failures++;
            $display("FAIL async_reset got %h want %h", obs, RST_VEC);
        end
        model_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        step_cycle(1'b0, 1'b1);
        step_cycle(1'b1, 1'b0);
        checks++;
        if ({ball_x, ball_y} !== {10'd318, 10'd238} || obs !== exp_vec()) begin
            failures++;
            $display("FAIL serve_after_reset got x=%0d y=%0d want x=318 y=238", ball_x, ball_y);
        end
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_serve_tick_same_cycle();
        test_bounces();
        test_miss();
        test_random();
        test_reset_mid_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
- Consumes the periodic game-tick strobe from the frame-rate tick generator.
- Advances the ball position once per tick and handles wall bounces, paddle hits and misses.
- Owns the serve / play / scored sequence.
- Outputs feed the VGA renderer (ball_x, ball_y) and the score counters (point_l, point_r).

Parameters:
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height in pixels
- BALL_SIZE, 8, ball edge length in pixels
- PADDLE_H, 64, paddle height in pixels
- PADDLE_W, 8, paddle width in pixels
- PADDLE_L_X, 16, left paddle x (left edge)
- PADDLE_R_X, 616, right paddle x (left edge)
- STEP, 2, pixels moved per tick on each axis
- SERVE_DELAY, 60, ticks held in SCORED before returning to IDLE

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low global reset
- tick  in  1  one-cycle strobe from the tick generator; motion rate
- serve  in  1  level/pulse serve request; honoured only in IDLE
- paddle_l_y  in  10  left paddle top y
- paddle_r_y  in  10  right paddle top y
- ball_x  out  10  ball left x, registered
- ball_y  out  10  ball top y, registered
- in_play  out  1  high in PLAY
- serve_ready  out  1  high in IDLE
- point_l  out  1  one-cycle pulse: left player scores (right miss)
- point_r  out  1  one-cycle pulse: right player scores (left miss)

Behaviour:
- Reset (reset=0, async):
  - state=IDLE
  - ball_x=(SCREEN_W-BALL_SIZE)/2=316, ball_y=(SCREEN_H-BALL_SIZE)/2=236
  - dx=right, dy=down, serve_dir=right, delay count=0
  - point_l=point_r=0, in_play=0, serve_ready=1
- States:
  - IDLE:
    - ball held at centre.
    - serve=1 -> PLAY, with dx=serve_dir and serve_dir toggled.
    - serve has priority over a coincident tick; first move occurs on the next tick.
  - PLAY: on each tick, apply the rules below. No change on non-tick cycles.
  - SCORED:
    - ball frozen at its final position; counts ticks.
    - After SERVE_DELAY ticks -> IDLE with ball re-centred; dy keeps its last value.
    - serve is ignored in this state.
- PLAY tick rules (all registered; outputs reflect the tick one cycle after tick is sampled high; paddle y sampled on the tick cycle):
  - Vertical, moving up: if ball_y < STEP, then ball_y=0 and dy=down; else ball_y -= STEP.
  - Vertical, moving down: if ball_y+BALL_SIZE+STEP > SCREEN_H, then ball_y=SCREEN_H-BALL_SIZE and dy=up; else ball_y += STEP.
  - Left paddle hit, all of:
    - dx=left
    - ball_x >= PADDLE_L_X+PADDLE_W
    - ball_x-STEP <= PADDLE_L_X+PADDLE_W
    - ball_y+BALL_SIZE > paddle_l_y
    - ball_y < paddle_l_y+PADDLE_H
    - Result: ball_x=PADDLE_L_X+PADDLE_W, dx=right.
  - Right paddle hit is the mirror case: ball_x+BALL_SIZE+STEP >= PADDLE_R_X -> ball_x=PADDLE_R_X-BALL_SIZE, dx=left.
  - Left miss: dx=left, no hit, ball_x < STEP. Result: ball_x=0, point_r pulses for 1 cycle, state -> SCORED.
  - Right miss: dx=right, no hit, ball_x+BALL_SIZE+STEP > SCREEN_W. Result: ball_x=SCREEN_W-BALL_SIZE, point_l pulses, state -> SCORED.
  - Otherwise, x moves by STEP in direction dx.
  - Corner case: vertical and horizontal rules are evaluated independently in the same tick; a simultaneous wall bounce and paddle hit both apply.
- Arithmetic: 11-bit intermediates for all comparisons. No wrap; positions are clamped as above.
- Reset asserted mid-operation returns to the reset values immediately. No pending pulse survives reset.
- point_l and point_r are never high together, and each is never high for more than one cycle.

Decomposition:
- pong_pkg holds:
  - screen and paddle geometry defaults
  - state encoding (IDLE, PLAY, SCORED)
  - direction encoding (LEFT/RIGHT, UP/DOWN)
- One sub-module: pong_tick_delay, a tick-qualified down-counter.
  - Inputs: load, tick, count value.
  - Output: expire.
  - Used for SERVE_DELAY.

Test Plan:
- Reset release, no serve, 10 ticks -> ball stays at (316,236); serve_ready=1; no point pulses.
- serve in IDLE, then 1 tick -> ball (318,238); in_play=1; serve_dir now left.
- PLAY, dy=up, ball_y=1, tick -> ball_y=0, dy=down; next tick ball_y=2.
- dx=left, ball_x=25, paddle_l_y=200, ball_y=220, tick -> ball_x=24, dx=right; next tick ball_x=26.
- dx=left, ball_x=1, paddle_l_y=400, ball_y=100, tick -> ball_x=0; point_r high exactly 1 cycle; SCORED; after 60 ticks -> IDLE at (316,236).
- serve and tick in the same cycle in IDLE -> ball unmoved that tick; moves on the next tick. reset pulled low mid-PLAY -> outputs return to reset values asynchronously.
